// File: rtl/frame_sync_ctrl.sv
// Frame-alignment controller for a serial bit stream with a fixed sync word at the
// start of every frame. It hunts for the sync word, confirms it on the following
// frame boundaries, then delivers payload bits and drops lock after repeated misses.
module frame_sync_ctrl #(
  parameter int unsigned       SYNC_W    = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = 4'b1010,
  parameter int unsigned       FRAME_LEN = 16,
  parameter int unsigned       LOCK_CNT  = 2,
  parameter int unsigned       MISS_CNT  = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_in_valid,
  input  logic       i_in,
  output logic [1:0] o_state,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic       o_sync_err,
  output logic       o_data_valid,
  output logic       o_data_bit
);

  localparam int unsigned PosW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned FillW = $clog2(SYNC_W + 1);
  localparam int unsigned GoodW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int unsigned MissW = (MISS_CNT > 1) ? $clog2(MISS_CNT) : 1;

  localparam logic [PosW-1:0]  PosSlot   = PosW'(FRAME_LEN - 1);
  localparam logic [PosW-1:0]  PosPayEnd = PosW'(FRAME_LEN - SYNC_W);
  localparam logic [FillW-1:0] FillMax   = FillW'(SYNC_W);
  localparam logic [FillW-1:0] FillMatch = FillW'(SYNC_W - 1);
  localparam logic [GoodW-1:0] GoodLast  = GoodW'(LOCK_CNT - 1);
  localparam logic [MissW-1:0] MissLast  = MissW'(MISS_CNT - 1);

  typedef enum logic [1:0] {
    StHunt    = 2'b00,
    StVerify  = 2'b01,
    StLocked  = 2'b10,
    StIllegal = 2'b11
  } state_e;

  state_e            r_state, w_state_d;
  logic [SYNC_W-1:0] r_shreg, w_shreg_d, w_shreg_n;
  logic [FillW-1:0]  r_fill, w_fill_d;
  logic [PosW-1:0]   r_pos, w_pos_d;
  logic [GoodW-1:0]  r_good, w_good_d;
  logic [MissW-1:0]  r_miss, w_miss_d;

  logic r_locked, w_locked_d;
  logic r_frame_start, w_frame_start_d;
  logic r_sync_err, w_sync_err_d;
  logic r_data_valid, w_data_valid_d;
  logic r_data_bit, w_data_bit_d;

  logic w_match, w_slot, w_payload;

  // Candidate window including the incoming bit; needs SYNC_W real bits to match.
  assign w_shreg_n = {r_shreg[SYNC_W-2:0], i_in};
  assign w_match   = (w_shreg_n == SYNC_PAT) && (r_fill >= FillMatch);
  assign w_slot    = (r_pos == PosSlot);
  assign w_payload = (r_pos < PosPayEnd);

  // State, datapath and output registers; reset or enable=0 clears everything.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || !i_enable) begin
      r_state       <= StHunt;
      r_shreg       <= '0;
      r_fill        <= '0;
      r_pos         <= '0;
      r_good        <= '0;
      r_miss        <= '0;
      r_locked      <= 1'b0;
      r_frame_start <= 1'b0;
      r_sync_err    <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data_bit    <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_shreg       <= w_shreg_d;
      r_fill        <= w_fill_d;
      r_pos         <= w_pos_d;
      r_good        <= w_good_d;
      r_miss        <= w_miss_d;
      r_locked      <= w_locked_d;
      r_frame_start <= w_frame_start_d;
      r_sync_err    <= w_sync_err_d;
      r_data_valid  <= w_data_valid_d;
      r_data_bit    <= w_data_bit_d;
    end
  end

  // Next-state and counter update; nothing moves without an accepted bit.
  always_comb begin
    w_state_d = r_state;
    w_shreg_d = r_shreg;
    w_fill_d  = r_fill;
    w_pos_d   = r_pos;
    w_good_d  = r_good;
    w_miss_d  = r_miss;

    // The shift register keeps running across loss of lock.
    if (i_in_valid) begin
      w_shreg_d = w_shreg_n;
      if (r_fill != FillMax) w_fill_d = r_fill + 1'b1;
    end

    unique case (r_state)
      StHunt: begin
        w_pos_d = '0;
        if (i_in_valid && w_match) begin
          w_state_d = StVerify;
          w_good_d  = '0;
        end
      end
      StVerify: begin
        if (i_in_valid) begin
          if (w_slot) begin
            w_pos_d = '0;
            if (!w_match) begin
              w_state_d = StHunt;
            end else if (r_good == GoodLast) begin
              w_state_d = StLocked;
              w_miss_d  = '0;
            end else begin
              w_good_d = r_good + 1'b1;
            end
          end else begin
            w_pos_d = r_pos + 1'b1;
          end
        end
      end
      StLocked: begin
        if (i_in_valid) begin
          if (w_slot) begin
            w_pos_d = '0;
            if (w_match) begin
              w_miss_d = '0;
            end else if (r_miss == MissLast) begin
              w_state_d = StHunt;
              w_miss_d  = '0;
            end else begin
              w_miss_d = r_miss + 1'b1;
            end
          end else begin
            w_pos_d = r_pos + 1'b1;
          end
        end
      end
      default: begin
        w_state_d = StHunt;
        w_pos_d   = '0;
        w_good_d  = '0;
        w_miss_d  = '0;
      end
    endcase
  end

  // Next values of the registered outputs; pulses only follow an accepted bit.
  always_comb begin
    w_locked_d      = (w_state_d == StLocked);
    w_frame_start_d = 1'b0;
    w_sync_err_d    = 1'b0;
    w_data_valid_d  = 1'b0;
    w_data_bit_d    = 1'b0;
    if (i_in_valid) begin
      if (r_state == StVerify) begin
        w_frame_start_d = w_slot && w_match && (r_good == GoodLast);
      end else if (r_state == StLocked) begin
        if (w_slot) begin
          w_frame_start_d = w_match;
          w_sync_err_d    = !w_match;
        end else if (w_payload) begin
          w_data_valid_d = 1'b1;
          w_data_bit_d   = i_in;
        end
      end
    end
  end

  assign o_state       = r_state;
  assign o_locked      = r_locked;
  assign o_frame_start = r_frame_start;
  assign o_sync_err    = r_sync_err;
  assign o_data_valid  = r_data_valid;
  assign o_data_bit    = r_data_bit;

endmodule
